// File: rtl/vga_sync_gen_if.sv
// Bundle between the horizontal pixel counter, the sync decoder and the pixel pipeline.
// master drives the horizontal count; slave (the decoder) drives the sync/timing outputs.
interface vga_sync_gen_if;
  localparam int unsigned HW = 11;
  localparam int unsigned VW = 10;

  logic [HW-1:0] h_cnt;
  logic          hs;
  logic          vs;
  logic          de;
  logic [HW-1:0] x;
  logic [VW-1:0] y;
  logic          line_end;
  logic          frame_start;

  modport master (output h_cnt, input hs, vs, de, x, y, line_end, frame_start);
  modport slave  (input h_cnt, output hs, vs, de, x, y, line_end, frame_start);
endinterface

// File: rtl/vga_sync_gen.sv
// Vertical line counter plus registered HSYNC/VSYNC/DE/coordinate/strobe decode.
// Define VGA_SYNC_ACTIVE_LOW_EN for active-low HSYNC/VSYNC (reset level 1).
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 56,
  parameter int unsigned H_SYNC   = 120,
  parameter int unsigned H_LAST   = 1040,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 37,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_TOTAL  = 666
) (
  input  logic           CLK,
  input  logic           RST,
  vga_sync_gen_if.slave  bus
);
  localparam int unsigned HW = 11;
  localparam int unsigned VW = 10;
  localparam int unsigned CW = 12;

`ifdef VGA_SYNC_ACTIVE_LOW_EN
  localparam logic SYNC_ON = 1'b0;
`else
  localparam logic SYNC_ON = 1'b1;
`endif
  localparam logic SYNC_OFF = ~SYNC_ON;

  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_MAX    = VW'(V_TOTAL - 1);

  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          de_q, de_d;
  logic [HW-1:0] x_q, x_d;
  logic [VW-1:0] y_q, y_d;
  logic          line_end_q, line_end_d;
  logic          frame_start_q, frame_start_d;

  logic [CW-1:0] h_w;
  logic [CW-1:0] v_w;
  logic          in_range_c;

  assign h_w        = CW'(bus.h_cnt);
  assign v_w        = CW'(v_cnt_q);
  assign in_range_c = (h_w <= CW'(H_LAST));

  // Decode on the current count and the pre-update line number.
  always_comb begin
    v_cnt_d       = v_cnt_q;
    line_end_d    = (h_w == CW'(H_LAST));
    de_d          = in_range_c && (h_w < CW'(H_ACTIVE)) && (v_w < CW'(V_ACTIVE));
    hs_d          = (in_range_c && (h_w >= HS_START) && (h_w < HS_END)) ? SYNC_ON : SYNC_OFF;
    vs_d          = ((v_w >= VS_START) && (v_w < VS_END)) ? SYNC_ON : SYNC_OFF;
    x_d           = de_d ? bus.h_cnt : '0;
    y_d           = de_d ? v_cnt_q : '0;
    frame_start_d = (h_w == '0) && (v_cnt_q == '0);
    if (line_end_d) begin
      v_cnt_d = (v_cnt_q == V_MAX) ? '0 : v_cnt_q + VW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      v_cnt_q       <= '0;
      hs_q          <= SYNC_OFF;
      vs_q          <= SYNC_OFF;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      v_cnt_q       <= v_cnt_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_end_q    <= line_end_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.hs          = hs_q;
  assign bus.vs          = vs_q;
  assign bus.de          = de_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.line_end    = line_end_q;
  assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: vector table, horizontal sweep, fast frame walk, wrap, mid-frame reset.
module tb_vga_sync_gen;
`ifdef VGA_SYNC_ACTIVE_LOW_EN
  localparam logic ON = 1'b0;
`else
  localparam logic ON = 1'b1;
`endif

  logic CLK;
  logic RST;
  vga_sync_gen_if bus ();

  vga_sync_gen dut (.CLK(CLK), .RST(RST), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit          rst;
    int unsigned h;
    bit          hs;
    bit          vs;
    bit          de;
    int unsigned x;
    int unsigned y;
    bit          le;
    bit          fs;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one count for one clock; outputs for it are visible 1 time unit after the edge.
  task automatic drive(input bit rst, input int unsigned h);
    RST = rst;
    bus.h_cnt = 11'(h);
    @(posedge CLK);
    #1;
  endtask

  function automatic logic lvl(input bit active);
    return active ? ON : ~ON;
  endfunction

  initial begin
    int fs_seen;
    int line;
    logic [15:0] bad;
    RST = 1'b1;
    bus.h_cnt = '0;

    vecs[0]  = '{1, 5,    0, 0, 0, 0,   0, 0, 0};
    vecs[1]  = '{1, 6,    0, 0, 0, 0,   0, 0, 0};
    vecs[2]  = '{1, 1040, 0, 0, 0, 0,   0, 0, 0};
    vecs[3]  = '{0, 0,    0, 0, 1, 0,   0, 0, 1};
    vecs[4]  = '{0, 1,    0, 0, 1, 1,   0, 0, 0};
    vecs[5]  = '{0, 799,  0, 0, 1, 799, 0, 0, 0};
    vecs[6]  = '{0, 800,  0, 0, 0, 0,   0, 0, 0};
    vecs[7]  = '{0, 855,  0, 0, 0, 0,   0, 0, 0};
    vecs[8]  = '{0, 856,  1, 0, 0, 0,   0, 0, 0};
    vecs[9]  = '{0, 975,  1, 0, 0, 0,   0, 0, 0};
    vecs[10] = '{0, 976,  0, 0, 0, 0,   0, 0, 0};
    vecs[11] = '{0, 1039, 0, 0, 0, 0,   0, 0, 0};
    vecs[12] = '{0, 1040, 0, 0, 0, 0,   0, 1, 0};
    vecs[13] = '{0, 0,    0, 0, 1, 0,   1, 0, 0};
    vecs[14] = '{0, 1100, 0, 0, 0, 0,   0, 0, 0};
    vecs[15] = '{0, 2047, 0, 0, 0, 0,   0, 0, 0};
    vecs[16] = '{0, 0,    0, 0, 1, 0,   1, 0, 0};
    vecs[17] = '{0, 500,  0, 0, 1, 500, 1, 0, 0};

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].rst, vecs[i].h);
      chk($sformatf("v%0d_hs", i), 16'(bus.hs), 16'(lvl(vecs[i].hs)));
      chk($sformatf("v%0d_vs", i), 16'(bus.vs), 16'(lvl(vecs[i].vs)));
      chk($sformatf("v%0d_de", i), 16'(bus.de), 16'(vecs[i].de));
      chk($sformatf("v%0d_x", i), 16'(bus.x), 16'(vecs[i].x));
      chk($sformatf("v%0d_y", i), 16'(bus.y), 16'(vecs[i].y));
      chk($sformatf("v%0d_le", i), 16'(bus.line_end), 16'(vecs[i].le));
      chk($sformatf("v%0d_fs", i), 16'(bus.frame_start), 16'(vecs[i].fs));
    end

    // Full horizontal sweep on line 1.
    for (int h = 0; h <= 1040; h++) begin
      drive(0, h);
      bad = '0;
      if (bus.de !== (h < 800)) bad[0] = 1'b1;
      if (bus.x !== ((h < 800) ? 11'(h) : 11'd0)) bad[1] = 1'b1;
      if (bus.y !== ((h < 800) ? 10'd1 : 10'd0)) bad[2] = 1'b1;
      if (bus.hs !== lvl(h >= 856 && h <= 975)) bad[3] = 1'b1;
      if (bus.line_end !== (h == 1040)) bad[4] = 1'b1;
      if (bus.vs !== lvl(0) || bus.frame_start !== 1'b0) bad[5] = 1'b1;
      chk($sformatf("sweep_h%0d_badmask", h), bad, 16'd0);
    end

    // Walk lines 2..665 with three counts per line.
    fs_seen = 0;
    for (line = 2; line < 666; line++) begin
      drive(0, 0);
      if (bus.frame_start === 1'b1) fs_seen++;
      chk($sformatf("l%0d_de", line), 16'(bus.de), 16'(line < 600));
      chk($sformatf("l%0d_y", line), 16'(bus.y), (line < 600) ? 16'(line) : 16'd0);
      chk($sformatf("l%0d_vs", line), 16'(bus.vs), 16'(lvl(line >= 637 && line <= 642)));
      drive(0, 900);
      chk($sformatf("l%0d_hs", line), 16'(bus.hs), 16'(lvl(1)));
      drive(0, 1040);
      chk($sformatf("l%0d_le", line), 16'(bus.line_end), 16'd1);
    end

    // Wrap from line 665 back to line 0.
    drive(0, 0);
    if (bus.frame_start === 1'b1) fs_seen++;
    chk("wrap_fs", 16'(bus.frame_start), 16'd1);
    chk("wrap_de", 16'(bus.de), 16'd1);
    chk("wrap_y", 16'(bus.y), 16'd0);
    chk("wrap_vs", 16'(bus.vs), 16'(lvl(0)));
    chk("frame_start_count", 16'(fs_seen), 16'd1);

    // Reset mid-frame at line 300, H_CNT=400.
    for (int i = 0; i < 300; i++) drive(0, 1040);
    drive(0, 399);
    chk("pre_rst_y", 16'(bus.y), 16'd300);
    drive(1, 400);
    chk("mid_rst_de", 16'(bus.de), 16'd0);
    chk("mid_rst_y", 16'(bus.y), 16'd0);
    chk("mid_rst_hs", 16'(bus.hs), 16'(lvl(0)));
    chk("mid_rst_vs", 16'(bus.vs), 16'(lvl(0)));
    drive(0, 401);
    chk("post_rst_de", 16'(bus.de), 16'd1);
    chk("post_rst_x", 16'(bus.x), 16'd401);
    chk("post_rst_y", 16'(bus.y), 16'd0);
    drive(0, 1040);
    chk("post_rst_le", 16'(bus.line_end), 16'd1);
    drive(0, 0);
    chk("post_rst_next_y", 16'(bus.y), 16'd1);
    chk("post_rst_next_de", 16'(bus.de), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
